// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register that sits right after the 32x32 two-port register
// file. It captures the decoded instruction and the PA/PB operands. A
// register-file write landing on the same edge is folded into the captured
// operands (write-through). Toward EX it presents operands forwarded from
// EX/MEM and MEM/WB. It also detects load-use hazards: it holds the front end
// and inserts a bubble.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   valid_in                   decode slot holds a real instruction
//   ra_in, rb_in, rd_in        source / destination register numbers
//   pa_in, pb_in               register file read data
//   imm_in                     sign-extended immediate
//   alu_op_in, reg_we_in, mem_rd_in, mem_wr_in, use_imm_in
//                              decoded controls
//   flush                      kill the decode-slot instruction
//   exmem_we/rd/result         EX/MEM writeback candidate
//   memwb_we/rd/data           MEM/WB writeback (register file write port)
//   stall_out                  hold PC and IF/ID (combinational)
//   valid_out ... imm_out      registered instruction fields
//   a_out, b_out               forwarded operands (b_out is also store data)
//
// Handshake: valid_out marks a real instruction in EX. stall_out acts as the
// not-ready signal toward the front end. While stall_out is high, the decode
// slot must present the same instruction again on the next cycle. This
// stage captures a bubble in that cycle, so the held instruction is taken
// exactly one cycle later.
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [4:0]  ra_in,
    input  logic [4:0]  rb_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] pa_in,
    input  logic [31:0] pb_in,
    input  logic [31:0] imm_in,
    input  logic [3:0]  alu_op_in,
    input  logic        reg_we_in,
    input  logic        mem_rd_in,
    input  logic        mem_wr_in,
    input  logic        use_imm_in,
    input  logic        flush,
    input  logic        exmem_we,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_we,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic        stall_out,
    output logic        valid_out,
    output logic        reg_we_out,
    output logic        mem_rd_out,
    output logic        mem_wr_out,
    output logic        use_imm_out,
    output logic [3:0]  alu_op_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  ra_out,
    output logic [4:0]  rb_out,
    output logic [31:0] imm_out,
    output logic [31:0] a_out,
    output logic [31:0] b_out
);

    logic [31:0] pa_q;
    logic [31:0] pb_q;
    logic        hazard;
    logic        bubble;
    logic [31:0] pa_wt;
    logic [31:0] pb_wt;

    // Conservative load-use check: both sources are compared even when the
    // decoded instruction does not read one of them.
    assign hazard = valid_out & mem_rd_out & (rd_out != 5'd0) & valid_in &
                    ((rd_out == ra_in) | (rd_out == rb_in));

    // A flush makes the hazard moot. The instruction is killed anyway.
    assign stall_out = hazard & ~flush;

    assign bubble = flush | stall_out | ~valid_in;

    // The register file is written on the same edge this stage captures, so
    // PA/PB still hold the old value. Substitute the value being written.
    assign pa_wt = (memwb_we && (memwb_rd == ra_in) && (ra_in != 5'd0)) ? memwb_data : pa_in;
    assign pb_wt = (memwb_we && (memwb_rd == rb_in) && (rb_in != 5'd0)) ? memwb_data : pb_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out   <= 1'b0;
            reg_we_out  <= 1'b0;
            mem_rd_out  <= 1'b0;
            mem_wr_out  <= 1'b0;
            use_imm_out <= 1'b0;
            alu_op_out  <= 4'd0;
            rd_out      <= 5'd0;
            ra_out      <= 5'd0;
            rb_out      <= 5'd0;
            imm_out     <= 32'd0;
            pa_q        <= 32'd0;
            pb_q        <= 32'd0;
        end else if (bubble) begin
            valid_out   <= 1'b0;
            reg_we_out  <= 1'b0;
            mem_rd_out  <= 1'b0;
            mem_wr_out  <= 1'b0;
            use_imm_out <= 1'b0;
            alu_op_out  <= 4'd0;
            rd_out      <= 5'd0;
            ra_out      <= 5'd0;
            rb_out      <= 5'd0;
            imm_out     <= 32'd0;
            pa_q        <= 32'd0;
            pb_q        <= 32'd0;
        end else begin
            valid_out   <= 1'b1;
            reg_we_out  <= reg_we_in;
            mem_rd_out  <= mem_rd_in;
            mem_wr_out  <= mem_wr_in;
            use_imm_out <= use_imm_in;
            alu_op_out  <= alu_op_in;
            rd_out      <= rd_in;
            ra_out      <= ra_in;
            rb_out      <= rb_in;
            imm_out     <= imm_in;
            pa_q        <= pa_wt;
            pb_q        <= pb_wt;
        end
    end

    // Operand select. r0 always reads as zero. The younger EX/MEM result
    // wins over MEM/WB.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  r,
        input logic [31:0] q,
        input logic        ex_we,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_res,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_dat
    );
        logic [31:0] v;
        if (r == 5'd0)
            v = 32'd0;
        else if (ex_we && (ex_rd == r))
            v = ex_res;
        else if (wb_we && (wb_rd == r))
            v = wb_dat;
        else
            v = q;
        return v;
    endfunction

    always_comb begin
        a_out = fwd_sel(ra_out, pa_q, exmem_we, exmem_rd, exmem_result,
                        memwb_we, memwb_rd, memwb_data);
        b_out = fwd_sel(rb_out, pb_q, exmem_we, exmem_rd, exmem_result,
                        memwb_we, memwb_rd, memwb_data);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int OW = 121;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [4:0]  ra_in, rb_in, rd_in;
  logic [31:0] pa_in, pb_in, imm_in;
  logic [3:0]  alu_op_in;
  logic        reg_we_in, mem_rd_in, mem_wr_in, use_imm_in;
  logic        flush;
  logic        exmem_we;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_we;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        stall_out;
  logic        valid_out, reg_we_out, mem_rd_out, mem_wr_out, use_imm_out;
  logic [3:0]  alu_op_out;
  logic [4:0]  rd_out, ra_out, rb_out;
  logic [31:0] imm_out, a_out, b_out;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .ra_in(ra_in), .rb_in(rb_in), .rd_in(rd_in),
    .pa_in(pa_in), .pb_in(pb_in), .imm_in(imm_in),
    .alu_op_in(alu_op_in), .reg_we_in(reg_we_in), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .use_imm_in(use_imm_in), .flush(flush),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall_out(stall_out), .valid_out(valid_out), .reg_we_out(reg_we_out),
    .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out), .use_imm_out(use_imm_out),
    .alu_op_out(alu_op_out), .rd_out(rd_out), .ra_out(ra_out), .rb_out(rb_out),
    .imm_out(imm_out), .a_out(a_out), .b_out(b_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus and model types ----------------
  typedef struct packed {
    logic        valid;
    logic [4:0]  ra, rb, rd;
    logic [31:0] pa, pb, imm;
    logic [3:0]  alu_op;
    logic        reg_we, mem_rd, mem_wr, use_imm, flush;
    logic        exmem_we;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_we;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
  } stim_t;

  // Contents of the EX slot as the reference model sees it.
  typedef struct packed {
    logic        valid, reg_we, mem_rd, mem_wr, use_imm;
    logic [3:0]  alu_op;
    logic [4:0]  rd, ra, rb;
    logic [31:0] imm, pa, pb;
  } slot_t;

  slot_t       m;
  logic [OW-1:0] exp_q[$];
  string         name_q[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  int            cyc = 0;

  // ---------------- scoreboard primitives ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [OW-1:0] dut_vec();
    return {valid_out, reg_we_out, mem_rd_out, mem_wr_out, use_imm_out, alu_op_out,
            rd_out, ra_out, rb_out, imm_out, a_out, b_out, stall_out};
  endfunction

  // ---------------- reference model ----------------
  // Operand value EX sees for register r whose captured value is q.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] q, input stim_t s);
    if (r == 0) return 32'd0;
    if (s.exmem_we && s.exmem_rd == r) return s.exmem_result;
    if (s.memwb_we && s.memwb_rd == r) return s.memwb_data;
    return q;
  endfunction

  function automatic logic stall_of(input slot_t e, input stim_t s);
    logic load_in_ex, uses;
    load_in_ex = e.valid && e.mem_rd && e.rd != 0;
    uses       = s.valid && (e.rd == s.ra || e.rd == s.rb);
    return load_in_ex && uses && !s.flush;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] r, input logic [31:0] d, input stim_t s);
    return (s.memwb_we && s.memwb_rd == r && r != 0) ? s.memwb_data : d;
  endfunction

  function automatic slot_t next_slot(input slot_t e, input stim_t s);
    slot_t n;
    n = '0;
    if (s.valid && !s.flush && !stall_of(e, s)) begin
      n.valid = 1'b1;  n.reg_we = s.reg_we;  n.mem_rd = s.mem_rd;
      n.mem_wr = s.mem_wr;  n.use_imm = s.use_imm;  n.alu_op = s.alu_op;
      n.rd = s.rd;  n.ra = s.ra;  n.rb = s.rb;  n.imm = s.imm;
      n.pa = rf_read(s.ra, s.pa, s);
      n.pb = rf_read(s.rb, s.pb, s);
    end
    return n;
  endfunction

  function automatic logic [OW-1:0] expect_of(input slot_t e, input stim_t s);
    return {e.valid, e.reg_we, e.mem_rd, e.mem_wr, e.use_imm, e.alu_op,
            e.rd, e.ra, e.rb, e.imm,
            operand(e.ra, e.pa, s), operand(e.rb, e.pb, s), stall_of(e, s)};
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input stim_t s);
    valid_in = s.valid;  ra_in = s.ra;  rb_in = s.rb;  rd_in = s.rd;
    pa_in = s.pa;  pb_in = s.pb;  imm_in = s.imm;  alu_op_in = s.alu_op;
    reg_we_in = s.reg_we;  mem_rd_in = s.mem_rd;  mem_wr_in = s.mem_wr;
    use_imm_in = s.use_imm;  flush = s.flush;
    exmem_we = s.exmem_we;  exmem_rd = s.exmem_rd;  exmem_result = s.exmem_result;
    memwb_we = s.memwb_we;  memwb_rd = s.memwb_rd;  memwb_data = s.memwb_data;
  endtask

  // One cycle: drive at the falling edge, queue the expected outputs for
  // this cycle, then advance the model across the coming rising edge.
  task automatic drive(input stim_t s, input string name);
    @(negedge clk);
    apply(s);
    exp_q.push_back(expect_of(m, s));
    name_q.push_back(name);
    m = next_slot(m, s);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid        = ($urandom_range(0, 3) != 0);
    s.ra           = 5'($urandom_range(0, 7));
    s.rb           = 5'($urandom_range(0, 7));
    s.rd           = 5'($urandom_range(0, 7));
    s.pa           = $urandom;
    s.pb           = $urandom;
    s.imm          = $urandom;
    s.alu_op       = 4'($urandom_range(0, 15));
    s.reg_we       = 1'($urandom_range(0, 1));
    s.mem_rd       = ($urandom_range(0, 2) == 0);
    s.mem_wr       = ($urandom_range(0, 3) == 0);
    s.use_imm      = 1'($urandom_range(0, 1));
    s.flush        = ($urandom_range(0, 7) == 0);
    s.exmem_we     = 1'($urandom_range(0, 1));
    s.exmem_rd     = 5'($urandom_range(0, 7));
    s.exmem_result = $urandom;
    s.memwb_we     = 1'($urandom_range(0, 1));
    s.memwb_rd     = 5'($urandom_range(0, 7));
    s.memwb_data   = $urandom;
    return s;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        logic [OW-1:0] e;
        string         n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        cyc++;
        if (dut_vec() !== e)
          $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, dut_vec(), e);
        total_cnt++;
        if (dut_vec() === e) pass_cnt++;
      end
    end
  end

  // ---------------- directed + random sequences ----------------
  initial begin
    stim_t s;
    stim_t ld;
    m = '0;
    apply('0);
    reset = 1'b1;
    #1;
    check("reset_initial", 128'(dut_vec()), 128'd0);
    @(negedge clk);
    @(negedge clk);
    #3 reset = 1'b0;

    // Forwarding priority on r3 with captured value 0x11.
    s = '0; s.valid = 1; s.ra = 3; s.rb = 2; s.rd = 1; s.pa = 32'h11; s.reg_we = 1;
    drive(s, "prio_setup");
    s = '0; s.exmem_we = 1; s.exmem_rd = 3; s.exmem_result = 32'hAA;
    s.memwb_we = 1; s.memwb_rd = 3; s.memwb_data = 32'hBB;
    drive(s, "prio_both");
    #1 check("prio_both_a", 128'(a_out), 128'h0000_00AA);
    s = '0; s.valid = 1; s.ra = 3; s.rb = 2; s.rd = 1; s.pa = 32'h11; s.reg_we = 1;
    drive(s, "prio_setup2");
    s = '0; s.memwb_we = 1; s.memwb_rd = 3; s.memwb_data = 32'hBB;
    s.exmem_rd = 3; s.exmem_result = 32'hAA;
    drive(s, "prio_memwb");
    #1 check("prio_memwb_a", 128'(a_out), 128'h0000_00BB);
    s = '0; s.valid = 1; s.ra = 3; s.rb = 2; s.rd = 1; s.pa = 32'h11; s.reg_we = 1;
    drive(s, "prio_setup3");
    s = '0; s.exmem_rd = 3; s.memwb_rd = 3; s.exmem_result = 32'hAA; s.memwb_data = 32'hBB;
    drive(s, "prio_none");
    #1 check("prio_none_a", 128'(a_out), 128'h11);

    // Write-through at capture.
    s = '0; s.valid = 1; s.ra = 5; s.rb = 6; s.pa = 32'h1; s.memwb_we = 1; s.memwb_rd = 5;
    s.memwb_data = 32'h55;
    drive(s, "wt_capture");
    s = '0;
    drive(s, "wt_use");
    #1 check("write_through_a", 128'(a_out), 128'h55);

    // Load-use: load r7 then a consumer of r7 on port B.
    ld = '0; ld.valid = 1; ld.rd = 7; ld.ra = 1; ld.mem_rd = 1; ld.reg_we = 1;
    drive(ld, "lu_load");
    s = '0; s.valid = 1; s.ra = 1; s.rb = 7; s.rd = 2; s.reg_we = 1; s.pb = 32'h3;
    drive(s, "lu_hazard");
    #1 check("lu_stall_high", 128'(stall_out), 128'd1);
    drive(s, "lu_bubble");
    #1 check("lu_bubble_valid", 128'(valid_out), 128'd0);
    check("lu_stall_low", 128'(stall_out), 128'd0);
    s = '0; s.memwb_we = 1; s.memwb_rd = 7; s.memwb_data = 32'h77;
    drive(s, "lu_forward");
    #1 check("lu_forward_b", 128'(b_out), 128'h77);
    check("lu_captured_valid", 128'(valid_out), 128'd1);

    // r0 guard.
    s = '0; s.valid = 1; s.ra = 0; s.rb = 4;
    drive(s, "r0_setup");
    s = '0; s.exmem_we = 1; s.exmem_rd = 0; s.exmem_result = 32'hFFFF_FFFF;
    drive(s, "r0_forward");
    #1 check("r0_forward_a", 128'(a_out), 128'd0);
    ld = '0; ld.valid = 1; ld.rd = 0; ld.mem_rd = 1; ld.reg_we = 1;
    drive(ld, "r0_load");
    s = '0; s.valid = 1; s.ra = 0; s.rb = 0;
    drive(s, "r0_nohazard");
    #1 check("r0_stall", 128'(stall_out), 128'd0);

    // Flush during a hazard.
    ld = '0; ld.valid = 1; ld.rd = 9; ld.mem_rd = 1; ld.reg_we = 1;
    drive(ld, "fl_load");
    s = '0; s.valid = 1; s.ra = 9; s.rd = 4; s.reg_we = 1; s.mem_wr = 1; s.flush = 1;
    drive(s, "fl_hazard");
    #1 check("flush_stall", 128'(stall_out), 128'd0);
    s = '0;
    drive(s, "fl_after");
    #1 check("flush_bubble", 128'({valid_out, reg_we_out, mem_wr_out}), 128'd0);

    // Reset while a load sits in EX and the decode slot depends on it.
    ld = '0; ld.valid = 1; ld.rd = 6; ld.mem_rd = 1; ld.reg_we = 1; ld.imm = 32'h1234;
    drive(ld, "rst_load");
    s = '0; s.valid = 1; s.ra = 6; s.rb = 6;
    drive(s, "rst_stall");
    #1 check("rst_pre_stall", 128'(stall_out), 128'd1);
    #2 reset = 1'b1;
    #1 check("reset_mid_stall", 128'(dut_vec()), 128'd0);
    #3 reset = 1'b0;
    m = '0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(rand_stim(), "random");
    end

    @(negedge clk);
    apply('0);
    #4;
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
